vm2002_change_dispenser: RTL and testbench

- Downstream of the vending FSM. It takes the computed change `balance` and pays it out one coin at a time to the coin-return mechanism.
- Payout is greedy (quarter, then dime, then nickel), limited by three internal coin-tube counters.
- Tubes are restocked by the supplier interface while the block is idle. A mechanism that never acknowledges a coin raises a sticky fault.

---
 rtl/vm2002_change_dispenser_if.sv | 35 +++
 rtl/vm2002_change_dispenser.sv | 207 ++++++++++++++++++++
 tb/tb_vm2002_change_dispenser.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vm2002_change_dispenser_if.sv
// Bus bundle for the change dispenser: payout command, coin-return handshake,
// tube refill port, fault control and status. The master side drives commands.
interface vm2002_change_dispenser_if #(
   parameter int LVL_W = 6
);
   logic             start;
   logic [15:0]      balance;
   logic [1:0]       coin_out;
   logic             coin_valid;
   logic             coin_ack;
   logic             busy;
   logic             done;
   logic             change_short;
   logic [15:0]      remaining;
   logic             refill_valid;
   logic [1:0]       refill_coin;
   logic [4:0]       refill_count;
   logic             clear_fault;
   logic             fault;
   logic [LVL_W-1:0] q_level;
   logic [LVL_W-1:0] d_level;
   logic [LVL_W-1:0] n_level;

   modport master (
      output start, balance, coin_ack, refill_valid, refill_coin, refill_count, clear_fault,
      input  coin_out, coin_valid, busy, done, change_short, remaining, fault,
             q_level, d_level, n_level
   );

   modport slave (
      input  start, balance, coin_ack, refill_valid, refill_coin, refill_count, clear_fault,
      output coin_out, coin_valid, busy, done, change_short, remaining, fault,
             q_level, d_level, n_level
   );
endinterface

// File: rtl/vm2002_change_dispenser.sv
// Greedy quarter/dime/nickel change payout from three coin tubes, with idle-time refill
// and a sticky ack-timeout fault. Define VM2002_CHANGE_STATS_EN for payout statistics.
module vm2002_change_dispenser #(
   parameter int TUBE_DEPTH  = 32,
   parameter int TUBE_INIT   = 10,
   parameter int ACK_TIMEOUT = 64
) (
   input logic                      clk,
   input logic                      hrst,
   vm2002_change_dispenser_if.slave bus
`ifdef VM2002_CHANGE_STATS_EN
   ,
   output logic [31:0]              total_paid,
   output logic [15:0]              short_events
`endif
);
   localparam int LVL_W = $clog2(TUBE_DEPTH + 1);
   localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
   localparam int SUM_W = LVL_W + 6;

   typedef enum logic [2:0] {IDLE, SELECT, ISSUE, DONE, FAULT} state_t;
   state_t state, next_state;

   logic [LVL_W-1:0] q_lvl, d_lvl, n_lvl;
   logic [LVL_W-1:0] refill_base, refill_new;
   logic [SUM_W-1:0] refill_sum;
   logic [15:0]      remaining;
   logic [1:0]       coin_out, sel_coin;
   logic [TMR_W-1:0] timer;
   logic             change_short;
   logic             busy, coin_valid, done, fault;
   logic             timeout, refill_en, ack_en;

   function automatic logic [15:0] coin_value(input logic [1:0] c);
      logic [15:0] v;
      v = 16'd0;
      case (c)
         2'b01:   v = 16'd5;
         2'b10:   v = 16'd10;
         2'b11:   v = 16'd25;
         default: v = 16'd0;
      endcase
      return v;
   endfunction

   assign timeout   = (timer == TMR_W'(ACK_TIMEOUT - 1));
   assign refill_en = (state == IDLE) && bus.refill_valid;
   assign ack_en    = (state == ISSUE) && bus.coin_ack;

   // Largest coin that fits the amount owed and is still in stock; 00 when nothing fits.
   always_comb begin
      sel_coin = 2'b00;
      if (remaining >= 16'd25 && q_lvl != '0)
         sel_coin = 2'b11;
      else if (remaining >= 16'd10 && d_lvl != '0)
         sel_coin = 2'b10;
      else if (remaining >= 16'd5 && n_lvl != '0)
         sel_coin = 2'b01;
   end

   always_comb begin
      refill_base = '0;
      case (bus.refill_coin)
         2'b01:   refill_base = n_lvl;
         2'b10:   refill_base = d_lvl;
         2'b11:   refill_base = q_lvl;
         default: refill_base = '0;
      endcase
      refill_sum = SUM_W'(refill_base) + SUM_W'(bus.refill_count);
      refill_new = (refill_sum > SUM_W'(TUBE_DEPTH)) ? LVL_W'(TUBE_DEPTH) : refill_sum[LVL_W-1:0];
   end

   always_ff @(posedge clk or posedge hrst) begin
      if (hrst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      busy       = 1'b1;
      coin_valid = 1'b0;
      done       = 1'b0;
      fault      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (bus.start)
               next_state = SELECT;
         end
         SELECT: begin
            if (sel_coin != 2'b00)
               next_state = ISSUE;
            else
               next_state = DONE;
         end
         ISSUE: begin
            coin_valid = 1'b1;
            if (bus.coin_ack)
               next_state = SELECT;
            else if (timeout)
               next_state = FAULT;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         FAULT: begin
            busy  = 1'b0;
            fault = 1'b1;
            if (bus.clear_fault)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // A short payout is flagged only when money is still owed and no coin fits.
   always_ff @(posedge clk or posedge hrst) begin
      if (hrst) begin
         remaining    <= '0;
         coin_out     <= 2'b00;
         timer        <= '0;
         change_short <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  remaining    <= bus.balance;
                  change_short <= 1'b0;
               end
            end
            SELECT: begin
               if (sel_coin != 2'b00) begin
                  coin_out <= sel_coin;
                  timer    <= '0;
               end else if (remaining != '0) begin
                  change_short <= 1'b1;
               end
            end
            ISSUE: begin
               if (bus.coin_ack) begin
                  remaining <= remaining - coin_value(coin_out);
                  coin_out  <= 2'b00;
               end else begin
                  timer <= timer + TMR_W'(1);
                  if (timeout)
                     coin_out <= 2'b00;
               end
            end
            FAULT: begin
               if (bus.clear_fault)
                  remaining <= '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge hrst) begin
      if (hrst) begin
         q_lvl <= LVL_W'(TUBE_INIT);
         d_lvl <= LVL_W'(TUBE_INIT);
         n_lvl <= LVL_W'(TUBE_INIT);
      end else begin
         if (refill_en && bus.refill_coin == 2'b11)
            q_lvl <= refill_new;
         else if (ack_en && coin_out == 2'b11)
            q_lvl <= q_lvl - LVL_W'(1);
         if (refill_en && bus.refill_coin == 2'b10)
            d_lvl <= refill_new;
         else if (ack_en && coin_out == 2'b10)
            d_lvl <= d_lvl - LVL_W'(1);
         if (refill_en && bus.refill_coin == 2'b01)
            n_lvl <= refill_new;
         else if (ack_en && coin_out == 2'b01)
            n_lvl <= n_lvl - LVL_W'(1);
      end
   end

`ifdef VM2002_CHANGE_STATS_EN
   // Paid total wraps naturally; short-event count sticks at its maximum.
   always_ff @(posedge clk or posedge hrst) begin
      if (hrst) begin
         total_paid   <= '0;
         short_events <= '0;
      end else begin
         if (ack_en)
            total_paid <= total_paid + 32'(coin_value(coin_out));
         if (state == DONE && change_short && short_events != 16'hFFFF)
            short_events <= short_events + 16'd1;
      end
   end
`endif

   assign bus.coin_out     = coin_out;
   assign bus.coin_valid   = coin_valid;
   assign bus.busy         = busy;
   assign bus.done         = done;
   assign bus.change_short = change_short;
   assign bus.remaining    = remaining;
   assign bus.fault        = fault;
   assign bus.q_level      = q_lvl;
   assign bus.d_level      = d_lvl;
   assign bus.n_level      = n_lvl;
endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Bench for vm2002_change_dispenser: directed plan steps plus randomized payouts
// checked against an arithmetic greedy-change model of the tubes.
module tb_vm2002_change_dispenser;
   localparam int TUBE_DEPTH  = 32;
   localparam int TUBE_INIT   = 10;
   localparam int ACK_TIMEOUT = 64;
   localparam int LVL_W       = $clog2(TUBE_DEPTH + 1);

   logic clk  = 1'b0;
   logic hrst = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   mq, md, mn;

   vm2002_change_dispenser_if #(.LVL_W(LVL_W)) bus ();

`ifdef VM2002_CHANGE_STATS_EN
   logic [31:0] total_paid;
   logic [15:0] short_events;
   int          m_paid;
   int          m_short;
`endif

   vm2002_change_dispenser #(
      .TUBE_DEPTH(TUBE_DEPTH),
      .TUBE_INIT(TUBE_INIT),
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk),
      .hrst(hrst),
      .bus(bus)
`ifdef VM2002_CHANGE_STATS_EN
      ,
      .total_paid(total_paid),
      .short_events(short_events)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_levels(input string tag);
      check_output({tag, "_q_level"}, 32'(bus.q_level), mq);
      check_output({tag, "_d_level"}, 32'(bus.d_level), md);
      check_output({tag, "_n_level"}, 32'(bus.n_level), mn);
   endtask

   function automatic int sat_add(input int lvl, input int cnt);
      return (lvl + cnt > TUBE_DEPTH) ? TUBE_DEPTH : lvl + cnt;
   endfunction

   task automatic model_refill(input int coin, input int cnt);
      case (coin)
         1: mn = sat_add(mn, cnt);
         2: md = sat_add(md, cnt);
         3: mq = sat_add(mq, cnt);
         default: ;
      endcase
   endtask

   task automatic apply_stimulus_defaults();
      bus.start        = 1'b0;
      bus.balance      = 16'd0;
      bus.coin_ack     = 1'b0;
      bus.refill_valid = 1'b0;
      bus.refill_coin  = 2'b00;
      bus.refill_count = 5'd0;
      bus.clear_fault  = 1'b0;
   endtask

   task automatic do_refill(input int coin, input int cnt);
      @(negedge clk);
      bus.refill_valid = 1'b1;
      bus.refill_coin  = 2'(coin);
      bus.refill_count = 5'(cnt);
      @(negedge clk);
      bus.refill_valid = 1'b0;
      model_refill(coin, cnt);
   endtask

   // Full payout: greedy counts are computed arithmetically, then the DUT's coin stream is compared.
   task automatic run_payout(input int bal, input int lat, input int rcoin, input int rcnt);
      int         nq, nd, nn, rem;
      logic [1:0] exp_coins[$];
      logic [1:0] want;
      bit         finished;
      model_refill(rcoin, rcnt);
      rem = bal;
      nq = rem / 25; if (nq > mq) nq = mq; rem -= 25 * nq;
      nd = rem / 10; if (nd > md) nd = md; rem -= 10 * nd;
      nn = rem / 5;  if (nn > mn) nn = mn; rem -= 5 * nn;
      repeat (nq) exp_coins.push_back(2'b11);
      repeat (nd) exp_coins.push_back(2'b10);
      repeat (nn) exp_coins.push_back(2'b01);

      @(negedge clk);
      bus.start        = 1'b1;
      bus.balance      = 16'(bal);
      bus.refill_valid = (rcoin != 0);
      bus.refill_coin  = 2'(rcoin);
      bus.refill_count = 5'(rcnt);
      @(negedge clk);
      bus.start        = 1'b0;
      bus.refill_valid = 1'b0;
      check_output("select_cycle_quiet", 32'({bus.coin_valid, bus.done}), 32'd0);
      @(negedge clk);
      check_output("first_event", 32'({bus.coin_valid, bus.done}),
                   (exp_coins.size() != 0) ? 32'd2 : 32'd1);

      finished = 1'b0;
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         if (bus.done) begin
            finished = 1'b1;
         end else if (bus.coin_valid) begin
            want = 2'b00;
            if (exp_coins.size() != 0) want = exp_coins.pop_front();
            check_output("coin_out", 32'(bus.coin_out), 32'(want));
            repeat (lat) @(negedge clk);
            bus.coin_ack = 1'b1;
            @(negedge clk);
            bus.coin_ack = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      mq -= nq; md -= nd; mn -= nn;
      check_output("done_seen", 32'(finished), 32'd1);
      check_output("coins_left", exp_coins.size(), 32'd0);
      check_output("change_short", 32'(bus.change_short), 32'(rem != 0));
      check_output("remaining", 32'(bus.remaining), rem);
      check_levels("payout");
`ifdef VM2002_CHANGE_STATS_EN
      m_paid += 25 * nq + 10 * nd + 5 * nn;
      if (rem != 0) m_short++;
`endif
      @(negedge clk);
      check_output("done_one_cycle", 32'({bus.done, bus.busy}), 32'd0);
`ifdef VM2002_CHANGE_STATS_EN
      check_output("total_paid", total_paid, m_paid);
      check_output("short_events", 32'(short_events), m_short);
`endif
   endtask

   initial begin
      int cnt;
      int rc;
      apply_stimulus_defaults();
      mq = TUBE_INIT; md = TUBE_INIT; mn = TUBE_INIT;
`ifdef VM2002_CHANGE_STATS_EN
      m_paid = 0; m_short = 0;
`endif
      #1 hrst = 1'b1;
      repeat (2) @(negedge clk);
      check_output("rst_coin_out", 32'(bus.coin_out), 32'd0);
      check_output("rst_flags", 32'({bus.coin_valid, bus.done, bus.change_short, bus.fault, bus.busy}), 32'd0);
      check_output("rst_remaining", 32'(bus.remaining), 32'd0);
      check_levels("rst");
      hrst = 1'b0;

      run_payout(40, 1, 0, 0);
      run_payout(225, 0, 0, 0);
      run_payout(30, 1, 0, 0);
      run_payout(7, 2, 0, 0);

      do_refill(3, 30);
      check_levels("refill_30");
      do_refill(3, 5);
      check_output("refill_saturate", 32'(bus.q_level), 32'd32);

      // Refill while a coin is outstanding must not touch the tube.
      @(negedge clk);
      bus.start = 1'b1; bus.balance = 16'd25;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      check_output("busy_refill_valid", 32'(bus.coin_valid), 32'd1);
      bus.refill_valid = 1'b1; bus.refill_coin = 2'b01; bus.refill_count = 5'd5;
      @(negedge clk);
      bus.refill_valid = 1'b0;
      check_output("busy_refill_ignored", 32'(bus.n_level), mn);
      bus.coin_ack = 1'b1;
      @(negedge clk);
      bus.coin_ack = 1'b0;
      cnt = 0;
      while (!bus.done && cnt < 20) begin cnt++; @(negedge clk); end
      check_output("busy_refill_done", 32'(bus.done), 32'd1);
      mq -= 1;
`ifdef VM2002_CHANGE_STATS_EN
      m_paid += 25;
`endif
      @(negedge clk);

      // Ack never arrives: coin held for the full timeout, then sticky fault.
      bus.start = 1'b1; bus.balance = 16'd25;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      cnt = 0;
      while (bus.coin_valid && cnt < 200) begin cnt++; @(negedge clk); end
      check_output("timeout_valid_cycles", cnt, ACK_TIMEOUT);
      check_output("fault_state", 32'({bus.fault, bus.busy, bus.coin_valid}), 32'd4);
      check_output("fault_remaining_frozen", 32'(bus.remaining), 32'd25);
      bus.refill_valid = 1'b1; bus.refill_coin = 2'b10; bus.refill_count = 5'd3;
      @(negedge clk);
      bus.refill_valid = 1'b0;
      check_levels("fault");
      bus.clear_fault = 1'b1;
      @(negedge clk);
      bus.clear_fault = 1'b0;
      check_output("clear_fault", 32'({bus.fault, bus.busy}), 32'd0);
      check_output("clear_remaining", 32'(bus.remaining), 32'd0);
      run_payout(5, 1, 0, 0);

      for (int i = 0; i < 25; i++) begin
         rc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_payout(int'($urandom_range(0, 150)), int'($urandom_range(0, 3)), rc,
                    (rc != 0) ? int'($urandom_range(0, 31)) : 0);
      end

      // Reset in the middle of a coin handshake.
      do_refill(3, 31);
      @(negedge clk);
      bus.start = 1'b1; bus.balance = 16'd40;
      @(negedge clk);
      bus.start = 1'b0;
      cnt = 0;
      while (!bus.coin_valid && cnt < 20) begin cnt++; @(negedge clk); end
      check_output("pre_reset_valid", 32'(bus.coin_valid), 32'd1);
      #2 hrst = 1'b1;
      #1;
      check_output("async_reset_valid", 32'({bus.coin_valid, bus.busy}), 32'd0);
      mq = TUBE_INIT; md = TUBE_INIT; mn = TUBE_INIT;
      check_levels("async_reset");
      check_output("async_reset_remaining", 32'(bus.remaining), 32'd0);
`ifdef VM2002_CHANGE_STATS_EN
      m_paid = 0; m_short = 0;
`endif
      @(negedge clk);
      hrst = 1'b0;
      run_payout(40, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
